// File: rtl/pcu_pkg.sv
// rtl/pcu_pkg.sv - constants shared by the sbox, credit counter and pcu input buffer
// Contents: PCU_W (word width), PCU_IN_DEPTH (default buffer depth),
//           PCU_IN_PTR_W and ptr_width() (pointer width including the wrap bit).
package pcu_pkg;

    localparam int PCU_W        = 32;
    localparam int PCU_IN_DEPTH = 4;

    // Pointer carries one extra MSB so full and empty can be told apart.
    function automatic int ptr_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

    localparam int PCU_IN_PTR_W = $clog2(PCU_IN_DEPTH) + 1;

endpackage

// File: rtl/pcu_fifo_mem.sv
// rtl/pcu_fifo_mem.sv - DEPTH x W register array for the pcu input buffer
// Ports: clk, reset (sync, active-high, clears every entry),
//        we/waddr/wdata (synchronous write port),
//        raddr/rdata (asynchronous read port).
module pcu_fifo_mem #(
    parameter int W     = 32,
    parameter int DEPTH = 4,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [W-1:0]  wdata,
    input  logic [AW-1:0] raddr,
    output logic [W-1:0]  rdata
);

    logic [W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/pcu_in_fifo.sv
// rtl/pcu_in_fifo.sv - credit-returning input buffer between an sbox port and a PCU lane
// Ports: clk, reset (sync, active-high),
//        in_data/in_valid (sbox word stream, no backpressure),
//        credit_out (one-cycle pulse per dequeued word),
//        out_data/out_valid/out_ready (head word to the PCU),
//        count (occupancy 0..DEPTH), overflow (sticky push-while-full).
// Build option: PCU_IN_FIFO_BYPASS_EN lets a word pass straight through
//               when the buffer is empty and the PCU is ready.
module pcu_in_fifo
    import pcu_pkg::*;
#(
    parameter int W     = PCU_W,
    parameter int DEPTH = PCU_IN_DEPTH
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [W-1:0]             in_data,
    input  logic                     in_valid,
    output logic                     credit_out,
    output logic [W-1:0]             out_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     overflow
);

    localparam int PW = ptr_width(DEPTH);
    localparam int AW = PW - 1;

    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [W-1:0]  rdata;
    logic          empty;
    logic          full;
    logic          push;
    logic          pop;
    logic          credit_next;

    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[PW-1] != rd_ptr[PW-1]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign count = wr_ptr - rd_ptr;

    // Pops only ever come from storage; full uses pre-cycle pointers, so a
    // same-cycle pop never frees room for a push that arrives while full.
    assign pop = !empty && out_ready;

`ifdef PCU_IN_FIFO_BYPASS_EN
    logic bypass;

    assign bypass      = empty && in_valid && out_ready;
    assign push        = in_valid && !full && !bypass;
    assign out_valid   = !empty || bypass;
    assign out_data    = bypass ? in_data : rdata;
    assign credit_next = pop || bypass;
`else
    assign push        = in_valid && !full;
    assign out_valid   = !empty;
    assign out_data    = rdata;
    assign credit_next = pop;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            credit_out <= 1'b0;
            overflow   <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            credit_out <= credit_next;
            if (in_valid && full) begin
                overflow <= 1'b1;
            end
        end
    end

    pcu_fifo_mem #(
        .W     (W),
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_mem (
        .clk   (clk),
        .reset (reset),
        .we    (push),
        .waddr (wr_ptr[AW-1:0]),
        .wdata (in_data),
        .raddr (rd_ptr[AW-1:0]),
        .rdata (rdata)
    );

endmodule
